// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// ALU opcode encodings and the result-slot state type.
package alu_share_arb_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational ALU shared by both requesters.
// Shift amounts use B[4:0]; unused opcodes yield zero.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALUOp,
  output logic [WIDTH-1:0]    C
);

  logic [4:0] shamt;
  assign shamt = B[4:0];

  // Decode the opcode into the selected datapath result.
  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> shamt;
      ALU_SRA: C = WIDTH'($signed(A) >>> shamt);
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one ALU between two requesters,
// with a one-entry registered, id-tagged result slot.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_A,
  input  logic [WIDTH-1:0]    req0_B,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_A,
  input  logic [WIDTH-1:0]    req1_B,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_C,
  output logic                res_id
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [WIDTH-1:0]  res_c_q, res_c_d;
  logic              res_id_q, res_id_d;

  logic              slot_free;
  logic              gnt0, gnt1;
  logic              grant, sel;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_c;
  logic [ALU_OP_W-1:0] alu_op;

  // Slot is free when empty or being drained this cycle.
  assign slot_free = !reset &&
    ((state_q == ST_EMPTY) || res_ready);

  // Round-robin grant: on conflict favour the
  // requester that did not win the last transfer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slot_free) begin
      unique case ({req1_valid, req0_valid})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end
        default: ;
      endcase
    end
  end

  assign grant      = gnt0 | gnt1;
  assign sel        = gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_a  = sel ? req1_A  : req0_A;
  assign alu_b  = sel ? req1_B  : req0_B;
  assign alu_op = sel ? req1_op : req0_op;

  alu_share_arb_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .A     (alu_a),
    .B     (alu_b),
    .ALUOp (alu_op),
    .C     (alu_c)
  );

  // Slot FSM plus result/fairness next-state.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    res_c_d  = res_c_q;
    res_id_d = res_id_q;
    unique case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !grant)
                  state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (grant) begin
      res_c_d  = alu_c;
      res_id_d = sel;
      last_d   = sel;
    end
  end

  // State and result registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      last_q   <= !FIRST_PRI;
      res_c_q  <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      res_c_q  <= res_c_d;
      res_id_q <= res_id_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_C     = res_c_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: op table, arbitration,
// backpressure and reset sequences with a result queue.
module tb_alu_share_arb;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_A, req0_B;
  logic [2:0]    req0_op;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_A, req1_B;
  logic [2:0]    req1_op;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_C;
  logic          res_id;

  always #5 clk = ~clk;

  alu_share_arb #(
    .WIDTH     (W),
    .FIRST_PRI (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_C      (res_C),
    .res_id     (res_id)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] c;
  } res_t;

  vec_t tbl[10];
  res_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [2:0]   op);
    logic [4:0]   sh;
    logic [W-1:0] ones;
    logic [W-1:0] r;
    sh   = b[4:0];
    ones = '1;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a >> sh;
      3'd5: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~(ones >> sh);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: pop on consume, push on accept.
  always @(negedge clk) begin : mon
    res_t e;
    if (reset) begin
      sbq.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got %h want none",
                   res_C);
        end else begin
          e = sbq.pop_front();
          chk("sb_C", res_C, e.c);
          chk("sb_id", 32'(res_id), 32'(e.id));
        end
      end
      if (req0_valid && req0_ready)
        sbq.push_back('{1'b0,
          ref_alu(req0_A, req0_B, req0_op)});
      if (req1_valid && req1_ready)
        sbq.push_back('{1'b1,
          ref_alu(req1_A, req1_B, req1_op)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic drive_one(input vec_t v,
                           input int idx);
    int n;
    logic rdy;
    @(posedge clk); #1;
    if (v.id) begin
      req1_valid = 1'b1;
      req1_A = v.a; req1_B = v.b; req1_op = v.op;
    end else begin
      req0_valid = 1'b1;
      req0_A = v.a; req0_B = v.b; req0_op = v.op;
    end
    n = 0;
    @(negedge clk);
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 10) begin
      @(negedge clk);
      rdy = v.id ? req1_ready : req0_ready;
      n++;
    end
    chk($sformatf("tbl%0d_ready", idx), 32'(rdy), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("tbl%0d_valid", idx),
        32'(res_valid), 32'd1);
    chk($sformatf("tbl%0d_C", idx), res_C, v.exp);
    chk($sformatf("tbl%0d_id", idx),
        32'(res_id), 32'(v.id));
  endtask

  initial begin
    logic         exp_g;
    logic [W-1:0] held;
    logic         held_id;

    tbl[0] = '{1'b0, 32'd1, 32'd8, 3'b000, 32'd9};
    tbl[1] = '{1'b1, 32'd1, 32'd8, 3'b001, 32'hFFFFFFF9};
    tbl[2] = '{1'b1, 32'd1, 32'd8, 3'b010, 32'd0};
    tbl[3] = '{1'b1, 32'd1, 32'd8, 3'b011, 32'd9};
    tbl[4] = '{1'b0, 32'h8888FFFF, 32'd2, 3'b100,
               32'h22223FFF};
    tbl[5] = '{1'b0, 32'h8888FFFF, 32'd2, 3'b101,
               32'hE2223FFF};
    tbl[6] = '{1'b0, 32'h8888FFFF, 32'd2, 3'b111,
               32'd0};
    tbl[7] = '{1'b1, 32'hFFFFFFFF, 32'd1, 3'b000,
               32'd0};
    tbl[8] = '{1'b0, 32'h80000000, 32'h3F, 3'b101,
               32'hFFFFFFFF};
    tbl[9] = '{1'b1, 32'h12345678, 32'h5, 3'b110,
               32'd0};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_A = '0; req0_B = '0; req0_op = '0;
    req1_A = '0; req1_B = '0; req1_op = '0;
    res_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_C", res_C, 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    for (int i = 0; i < 10; i++)
      drive_one(tbl[i], i);

    // Reset while a result is held.
    @(posedge clk); #1;
    res_ready = 1'b0;
    req0_valid = 1'b1;
    req0_A = 32'd5; req0_B = 32'd6; req0_op = 3'b000;
    @(negedge clk);
    chk("mid_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(res_valid), 32'd1);
    chk("mid_C", res_C, 32'd11);
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst2_rdy0", 32'(req0_ready), 32'd0);
    chk("rst2_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_valid", 32'(res_valid), 32'd0);
    chk("rst2_C", res_C, 32'd0);
    chk("rst2_id", 32'(res_id), 32'd0);

    // Continuous conflict: grants alternate 0,1,...
    @(posedge clk); #1;
    reset = 1'b0;
    res_ready = 1'b1;
    req0_A = 32'd100; req0_B = 32'd3; req0_op = 3'b001;
    req1_A = 32'hF0; req1_B = 32'h3C; req1_op = 3'b011;
    exp_g = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("arb%0d_rdy0", k),
          32'(req0_ready), 32'(!exp_g));
      chk($sformatf("arb%0d_rdy1", k),
          32'(req1_ready), 32'(exp_g));
      if (k > 0) begin
        chk($sformatf("arb%0d_valid", k),
            32'(res_valid), 32'd1);
        chk($sformatf("arb%0d_id", k),
            32'(res_id), 32'(!exp_g));
      end
      @(posedge clk); #1;
      if (exp_g) begin
        req1_A = $urandom;
        req1_B = $urandom;
        req1_op = 3'($urandom_range(0, 7));
      end else begin
        req0_A = $urandom;
        req0_B = $urandom;
        req0_op = 3'($urandom_range(0, 7));
      end
      exp_g = !exp_g;
      @(negedge clk);
    end

    // Backpressure for three cycles with both valid.
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    held    = res_C;
    held_id = res_id;
    chk("bp_id", 32'(held_id), 32'(exp_g));
    exp_g = !exp_g;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_rdy0", k),
          32'(req0_ready), 32'd0);
      chk($sformatf("bp%0d_rdy1", k),
          32'(req1_ready), 32'd0);
      chk($sformatf("bp%0d_valid", k),
          32'(res_valid), 32'd1);
      chk($sformatf("bp%0d_C", k), res_C, held);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("resume_rdy0", 32'(req0_ready), 32'(!exp_g));
    chk("resume_rdy1", 32'(req1_ready), 32'(exp_g));

    // Drain and confirm nothing is left pending.
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_valid", 32'(res_valid), 32'd0);
    chk("drain_sbq", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
